// File: rtl/dispense_pkg.sv
// Shared types and constants for the source-inlet dispense sequencer.
// Holds the FSM state encoding and the one-hot pump phase values.
package dispense_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRIME  = 3'd1,
        PUMP   = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam logic [2:0] PHASE_OFF = 3'b000;
    localparam logic [2:0] PHASE_A   = 3'b001;
    localparam logic [2:0] PHASE_B   = 3'b010;
    localparam logic [2:0] PHASE_C   = 3'b100;

    // Peristaltic rotation order; an illegal code restarts at phase A.
    function automatic logic [2:0] next_phase(input logic [2:0] p);
        logic [2:0] n;
        case (p)
            PHASE_A: n = PHASE_B;
            PHASE_B: n = PHASE_C;
            PHASE_C: n = PHASE_A;
            default: n = PHASE_A;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pump_phase_gen.sv
// Three-phase peristaltic drive: holds each one-hot phase STEP_CYCLES cycles
// and flags the last cycle of every step with step_tick.
module pump_phase_gen
    import dispense_pkg::*;
#(
    parameter int STEP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       restart,
    output logic [2:0] pump_phase,
    output logic       step_tick
);

    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(STEP_CYCLES - 1);

    logic [TW-1:0] timer_r;
    logic [2:0]    phase_r;

    // Step timer and phase rotator; run low parks the pump at PHASE_OFF.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_r <= TW'(0);
            phase_r <= PHASE_OFF;
        end else if (!run) begin
            timer_r <= TW'(0);
            phase_r <= PHASE_OFF;
        end else if (restart) begin
            timer_r <= TW'(0);
            phase_r <= PHASE_A;
        end else if (timer_r == TIMER_LAST) begin
            timer_r <= TW'(0);
            phase_r <= next_phase(phase_r);
        end else begin
            timer_r <= timer_r + TW'(1);
        end
    end

    assign pump_phase = phase_r;
    assign step_tick  = (phase_r != PHASE_OFF) && (timer_r == TIMER_LAST);

endmodule

// File: rtl/source_dispense_sequencer.sv
// Source inlet sequencer: accepts dispense commands and runs the valve and
// peristaltic pump through prime, pump, settle and done phases.
module source_dispense_sequencer
    import dispense_pkg::*;
#(
    parameter int STEP_CYCLES  = 4,
    parameter int PRIME_CYCLES = 2,
    parameter int CNT_W        = 8,
    parameter int SETTLE_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CNT_W-1:0]    cmd_steps,
    input  logic [SETTLE_W-1:0] cmd_settle,
    input  logic                abort,
    output logic                valve_open,
    output logic [2:0]          pump_phase,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [CNT_W-1:0]    steps_done
);

    localparam int PW = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES) : 1;
    localparam logic [PW-1:0] PRIME_LAST = PW'(PRIME_CYCLES - 1);

    state_e                state_r;
    state_e                state_n;
    logic [CNT_W-1:0]      steps_r;
    logic [SETTLE_W-1:0]   settle_r;
    logic [SETTLE_W-1:0]   settle_cnt_r;
    logic [PW-1:0]         prime_cnt_r;
    logic [CNT_W-1:0]      steps_done_r;
    logic                  cmd_ready_r;
    logic                  valve_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  aborted_r;

    logic                  accept_s;
    logic                  abort_s;
    logic                  active_s;
    logic                  step_tick_s;
    logic                  last_step_s;
    logic                  pump_run_s;
    logic                  pump_restart_s;

    assign accept_s    = cmd_valid && (state_r == IDLE);
    assign active_s    = (state_r == PRIME) || (state_r == PUMP) || (state_r == SETTLE);
    assign abort_s     = abort && active_s;
    assign last_step_s = (steps_done_r == (steps_r - CNT_W'(1)));

    // Next-state decode; abort only matters while the inlet is active.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    state_n = (cmd_steps == CNT_W'(0)) ? DONE : PRIME;
                end else begin
                    state_n = IDLE;
                end
            end
            PRIME: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (prime_cnt_r == PRIME_LAST) begin
                    state_n = PUMP;
                end else begin
                    state_n = PRIME;
                end
            end
            PUMP: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (step_tick_s && last_step_s) begin
                    state_n = (settle_r == SETTLE_W'(0)) ? DONE : SETTLE;
                end else begin
                    state_n = PUMP;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (settle_cnt_r == (settle_r - SETTLE_W'(1))) begin
                    state_n = DONE;
                end else begin
                    state_n = SETTLE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The phase generator runs one cycle ahead so its outputs line up with PUMP.
    assign pump_run_s     = (state_n == PUMP);
    assign pump_restart_s = (state_r != PUMP) && (state_n == PUMP);

    pump_phase_gen #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_phase (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (pump_run_s),
        .restart    (pump_restart_s),
        .pump_phase (pump_phase),
        .step_tick  (step_tick_s)
    );

    // State register, phase counters and command latches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            prime_cnt_r  <= PW'(0);
            settle_cnt_r <= SETTLE_W'(0);
            steps_r      <= CNT_W'(0);
            settle_r     <= SETTLE_W'(0);
            steps_done_r <= CNT_W'(0);
        end else begin
            state_r      <= state_n;
            prime_cnt_r  <= ((state_r == PRIME) && (state_n == PRIME)) ? prime_cnt_r + PW'(1) : PW'(0);
            settle_cnt_r <= ((state_r == SETTLE) && (state_n == SETTLE)) ? settle_cnt_r + SETTLE_W'(1) : SETTLE_W'(0);
            if (accept_s) begin
                steps_r      <= cmd_steps;
                settle_r     <= cmd_settle;
                steps_done_r <= CNT_W'(0);
            end else if ((state_r == PUMP) && step_tick_s && !abort && (steps_done_r != steps_r)) begin
                steps_done_r <= steps_done_r + CNT_W'(1);
            end else begin
                steps_done_r <= steps_done_r;
            end
        end
    end

    // Output registers decoded from the upcoming state so they track state_r exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_ready_r <= 1'b1;
            valve_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            aborted_r   <= 1'b0;
        end else begin
            cmd_ready_r <= (state_n == IDLE);
            valve_r     <= (state_n == PRIME) || (state_n == PUMP);
            busy_r      <= (state_n != IDLE);
            done_r      <= (state_n == DONE);
            aborted_r   <= abort_s;
        end
    end

    assign cmd_ready  = cmd_ready_r;
    assign valve_open = valve_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign aborted    = aborted_r;
    assign steps_done = steps_done_r;

endmodule

// File: tb/tb_source_dispense_sequencer.sv
// Scoreboard bench for source_dispense_sequencer: each accepted command pushes
// its cycle-by-cycle expected output trace, a negedge monitor pops and compares.
module tb_source_dispense_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_steps;
    logic [7:0] cmd_settle;
    logic       abort;
    logic       valve_open;
    logic [2:0] pump_phase;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [7:0] steps_done;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    source_dispense_sequencer #(
        .STEP_CYCLES (4),
        .PRIME_CYCLES(2),
        .CNT_W       (8),
        .SETTLE_W    (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_settle (cmd_settle),
        .abort      (abort),
        .valve_open (valve_open),
        .pump_phase (pump_phase),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .steps_done (steps_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Fields: {ready, busy, valve, pump[2:0], done, aborted, steps_done[7:0]}
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            chk("trace", {16'h0, cmd_ready, busy, valve_open, pump_phase, done, aborted, steps_done},
                {16'h0, e});
        end
    end

    // Expected outputs for cycles T+1.. after an accept at T, from the timing rules.
    task automatic push_trace(input int s, input int st, input int ab, input int max_len);
        int total, k, sd, prev_sd;
        bit ab_on;
        logic rdy, bsy, vlv, dn, abt;
        logic [2:0] ph;
        total   = (s == 0) ? 2 : (2 + 4 * s + st + 2);
        ab_on   = (s > 0) && (ab >= 1) && (ab <= 2 + 4 * s + st);
        prev_sd = 0;
        for (int c = 1; c <= total; c++) begin
            rdy = 1'b0; bsy = 1'b1; vlv = 1'b0; ph = 3'b000; dn = 1'b0; abt = 1'b0; sd = s;
            if (ab_on && c == ab + 1) begin
                rdy = 1'b1; bsy = 1'b0; abt = 1'b1; sd = prev_sd;
            end else if (s == 0) begin
                sd = 0;
                if (c == 1) dn = 1'b1;
                else begin rdy = 1'b1; bsy = 1'b0; end
            end else if (c <= 2) begin
                vlv = 1'b1; sd = 0;
            end else if (c <= 2 + 4 * s) begin
                k = c - 3; vlv = 1'b1; ph = 3'b001 << ((k / 4) % 3); sd = k / 4;
            end else if (c <= 2 + 4 * s + st) begin
                sd = s;
            end else if (c == total - 1) begin
                dn = 1'b1;
            end else begin
                rdy = 1'b1; bsy = 1'b0;
            end
            if (max_len == 0 || c <= max_len)
                exp_q.push_back({rdy, bsy, vlv, ph, dn, abt, 8'(sd)});
            prev_sd = sd;
            if (ab_on && c == ab + 1) begin
                if (max_len == 0)
                    exp_q.push_back({1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 8'(sd)});
                break;
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (cmd_ready !== 1'b1) chk("ready_timeout", 32'(cmd_ready), 32'd1);
    endtask

    // Accept one command; leaves the caller at the start of cycle T+1.
    task automatic issue(input int s, input int st, input int ab, input int max_len, input bit ab_acc);
        wait_drain();
        #1;
        wait_ready();
        cmd_valid  = 1'b1;
        cmd_steps  = 8'(s);
        cmd_settle = 8'(st);
        abort      = ab_acc;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        abort      = 1'b0;
        cmd_steps  = 8'($urandom_range(0, 255));
        cmd_settle = 8'($urandom_range(0, 255));
        push_trace(s, st, ab, max_len);
        if (ab > 0) begin
            repeat (ab - 1) @(posedge clk);
            #1;
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_steps  = 8'd0;
        cmd_settle = 8'd0;
        abort      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_valve", 32'(valve_open), 32'd0);
        chk("rst_pump", 32'(pump_phase), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_steps", 32'(steps_done), 32'd0);
        @(posedge clk);

        issue(3, 5, 0, 0, 1'b0);
        issue(0, 0, 0, 0, 1'b0);
        issue(5, 0, 0, 0, 1'b0);
        issue(10, 3, 8, 0, 1'b0);
        issue(0, 4, 1, 0, 1'b0);
        issue(1, 1, 0, 0, 1'b1);
        issue(2, 2, 2, 0, 1'b0);
        issue(1, 2, 7, 0, 1'b0);

        // Second command held valid while the first is busy.
        issue(3, 5, 0, 0, 1'b0);
        cmd_valid  = 1'b1;
        cmd_steps  = 8'd4;
        cmd_settle = 8'd2;
        wait_ready();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        push_trace(4, 2, 0, 0);

        for (int i = 0; i < 3; i++) begin
            issue($urandom_range(0, 6), $urandom_range(0, 4), 0, 0, 1'b0);
        end

        // Reset while pumping.
        issue(5, 0, 0, 6, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valve", 32'(valve_open), 32'd0);
        chk("mid_rst_pump", 32'(pump_phase), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_steps", 32'(steps_done), 32'd0);
        chk("mid_rst_flags", 32'({done, aborted}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        issue(2, 1, 0, 0, 1'b0);
        wait_drain();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
